// File: rtl/mult_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : mult_arb_pkg
// Brief   : Shared types and constants for the shared-multiplier arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mult_arb_pkg;

    localparam int MULT_W        = 64;
    localparam int N_REQ_DEFAULT = 2;
    localparam int MULT_STAGES   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mult.sv
//------------------------------------------------------------------------------
// Module  : mult
// Brief   : Multi-cycle 64x64 multiplier (low 64 bits). done stays high after
//           completion until the next start.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult
    import mult_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [MULT_W-1:0] mcand,
    input  logic [MULT_W-1:0] mplier,
    input  logic              start,
    output logic [MULT_W-1:0] product,
    output logic              done
);

    localparam int         CHUNK   = MULT_W / MULT_STAGES;
    localparam int         STAGE_W = $clog2(MULT_STAGES);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(MULT_STAGES - 1);

    logic [MULT_W-1:0]  mcand_q,   mcand_d;
    logic [MULT_W-1:0]  mplier_q,  mplier_d;
    logic [MULT_W-1:0]  acc_q,     acc_d;
    logic [MULT_W-1:0]  product_q, product_d;
    logic [STAGE_W-1:0] stage_q,   stage_d;
    logic               run_q,     run_d;
    logic               done_q,    done_d;

    logic [MULT_W-1:0]  chunk_val;
    logic [MULT_W-1:0]  partial;

    // One CHUNK-wide slice of the multiplier is folded into the accumulator per cycle.
    always_comb begin
        chunk_val = MULT_W'(mplier_q[CHUNK*int'(stage_q) +: CHUNK]);
        partial   = (mcand_q * chunk_val) << (CHUNK*int'(stage_q));
    end

    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        stage_d   = stage_q;
        run_d     = run_q;
        done_d    = done_q;
        if (start) begin
            mcand_d  = mcand;
            mplier_d = mplier;
            acc_d    = '0;
            stage_d  = '0;
            run_d    = 1'b1;
            done_d   = 1'b0;
        end else if (run_q) begin
            acc_d   = acc_q + partial;
            stage_d = stage_q + 1'b1;
            if (stage_q == LAST_STAGE) begin
                run_d     = 1'b0;
                done_d    = 1'b1;
                product_d = acc_q + partial;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            stage_q   <= '0;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            stage_q   <= stage_d;
            run_q     <= run_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign done    = done_q;

endmodule

`default_nettype wire

// File: rtl/mult_arbiter.sv
//------------------------------------------------------------------------------
// Module  : mult_arbiter
// Brief   : Round-robin arbiter sharing one multiplier among N_REQ requesters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*MULT_W-1:0] req_mcand,
    input  logic [N_REQ*MULT_W-1:0] req_mplier,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [MULT_W-1:0]       resp_product,
    output logic                    busy
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [MULT_W-1:0] mcand_q, mcand_d;
    logic [MULT_W-1:0] mplier_q, mplier_d;
    logic [MULT_W-1:0] resp_product_q, resp_product_d;

    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand;
    int                cand_int;
    logic              mult_start;
    logic [MULT_W-1:0] mult_product;
    logic              mult_done;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        cand_int    = 0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_int = (int'(last_grant_q) + 1 + k) % N_REQ;
            cand     = IDX_W'(cand_int);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        resp_product_d = resp_product_q;
        req_ready      = '0;
        resp_valid     = '0;
        mult_start     = 1'b0;
        case (state_q)
            IDLE: begin
                // No grant while reset is held, so nothing is accepted and lost.
                if (grant_found && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    mcand_d      = req_mcand[MULT_W*int'(grant_idx) +: MULT_W];
                    mplier_d     = req_mplier[MULT_W*int'(grant_idx) +: MULT_W];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // Hold start until done drops so a stale done is never taken as ours.
                mult_start = 1'b1;
                if (!mult_done) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mult_done) begin
                    resp_product_d = mult_product;
                    state_d        = RESP;
                end
            end
            RESP: begin
                resp_valid[owner_q] = 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            last_grant_q   <= IDX_W'(N_REQ - 1);
            owner_q        <= '0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            resp_product_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            owner_q        <= owner_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            resp_product_q <= resp_product_d;
        end
    end

    mult u_mult (
        .clock   (clock),
        .reset   (reset),
        .mcand   (mcand_q),
        .mplier  (mplier_q),
        .start   (mult_start),
        .product (mult_product),
        .done    (mult_done)
    );

    assign resp_product = resp_product_q;
    assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_mult_arbiter
// Brief   : Directed self-checking bench for mult_arbiter (N_REQ = 2).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_arbiter;

    localparam int NR = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*64-1:0] req_mcand = '0;
    logic [NR*64-1:0] req_mplier = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    resp_valid;
    logic [63:0]      resp_product;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    mult_arbiter #(.N_REQ(NR)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_mcand    (req_mcand),
        .req_mplier   (req_mplier),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_product (resp_product),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; waits for the response pulse, then checks it lasts one cycle.
    task automatic wait_resp(input int owner, input logic [63:0] exp, input string tag);
        for (int k = 0; k < 40 && resp_valid == '0; k++) @(negedge clock);
        check({tag, "_valid"}, 64'(resp_valid), 64'(1 << owner));
        check({tag, "_prod"}, resp_product, exp);
        @(negedge clock);
        check({tag, "_pulse"}, 64'(resp_valid), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    // Single request from requester i; operands are scrambled after the grant.
    task automatic do_op(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input string tag);
        req_valid[i] = 1'b1;
        req_mcand[64*i +: 64]  = a;
        req_mplier[64*i +: 64] = b;
        #1;
        check({tag, "_ready"}, 64'(req_ready), 64'(1 << i));
        @(negedge clock);
        req_valid[i] = 1'b0;
        req_mcand[64*i +: 64]  = ~a;
        req_mplier[64*i +: 64] = ~b;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_resp(i, exp, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] saw;

        // Reset state, with a request pending during reset
        reset = 1'b1;
        repeat (3) @(negedge clock);
        req_valid = 2'b01;
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_product", resp_product, 64'd0);
        req_valid = '0;
        reset = 1'b0;

        do_op(0, 64'd3, 64'd5, 64'd15, "single");

        // Simultaneous requests straight after reset
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        req_valid = 2'b11;
        req_mcand  = {64'd9, 64'd7};
        req_mplier = {64'd9, 64'd6};
        #1;
        check("sim_first", 64'(req_ready), 64'b01);
        @(negedge clock);
        req_valid[0] = 1'b0;
        wait_resp(0, 64'd42, "sim0");
        check("sim_second", 64'(req_ready), 64'b10);
        @(negedge clock);
        req_valid[1] = 1'b0;
        wait_resp(1, 64'd81, "sim1");

        // Round-robin with both requesters held high
        req_valid = 2'b11;
        req_mcand  = {64'd4, 64'd2};
        req_mplier = {64'd5, 64'd3};
        for (int r = 0; r < 4; r++) begin
            #1;
            check($sformatf("rr%0d_grant", r), 64'(req_ready), 64'(1 << (r % 2)));
            wait_resp(r % 2, (r % 2 == 0) ? 64'd6 : 64'd20, $sformatf("rr%0d", r));
        end
        req_valid = '0;

        // Wide operands and truncation to the low 64 bits
        do_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "wide_a");
        do_op(1, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, "wide_b");
        do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, "wide_c");

        // Reset while waiting on the multiplier
        req_valid[0] = 1'b1;
        req_mcand[63:0]  = 64'd7;
        req_mplier[63:0] = 64'd7;
        @(negedge clock);
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clock);
        check("abort_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        saw = '0;
        repeat (2) begin
            @(negedge clock);
            saw |= resp_valid;
        end
        reset = 1'b0;
        repeat (10) begin
            @(negedge clock);
            saw |= resp_valid;
        end
        check("abort_no_resp", 64'(saw), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);
        do_op(1, 64'd5, 64'd5, 64'd25, "post_rst");

        // Back-to-back from the same requester over a stale done
        do_op(0, 64'd3, 64'd4, 64'd12, "b2b_a");
        do_op(0, 64'd6, 64'd7, 64'd42, "b2b_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
